mem_port_arbiter: RTL and testbench

//  Shares the single 128-bit main-memory port between two masters:
//   - the instruction fetch queue's line-read requests (i-side);
//   - the load/store unit's line read/write requests (d-side).

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/arb_pick.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the main-memory port arbiter.
//   LINE_W         width of one memory line (four instructions)
//   LINE_OFFSET_W  byte-offset bits inside a line
//   arb_state_t    arbiter FSM state encoding
//   line_align     clears the byte offset of an address
package mips_mem_pkg;

    localparam int LINE_W        = 128;
    localparam int LINE_OFFSET_W = 4;
    localparam int ADDR_MAX_W    = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_I_BUSY  = 2'd1,
        ST_I_DRAIN = 2'd2,
        ST_D_BUSY  = 2'd3
    } arb_state_t;

    // Works on the widest supported address; callers cast to their own width.
    function automatic logic [ADDR_MAX_W-1:0] line_align(input logic [ADDR_MAX_W-1:0] addr);
        logic [ADDR_MAX_W-1:0] mask;
        mask = {ADDR_MAX_W{1'b1}} << LINE_OFFSET_W;
        return addr & mask;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Grant selection and starvation counter for the memory port arbiter.
//   clock, nreset   clock and synchronous active-low reset
//   in_idle         arbiter is in IDLE and may grant this cycle
//   i_req, i_flush  i-side request and redirect (flush masks the request)
//   i_dout_valid    i-side completion pulse (masks the stale request level)
//   d_req           any d-side request (read or write)
//   d_dout_valid    d-side completion pulse
//   grant_i/grant_d one-hot grant, valid only while in_idle
module arb_pick
    import mips_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clock,
    input  logic nreset,
    input  logic in_idle,
    input  logic i_req,
    input  logic i_flush,
    input  logic i_dout_valid,
    input  logic d_req,
    input  logic d_dout_valid,
    output logic grant_i,
    output logic grant_d
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve;
    logic             starve_ok;
    logic             d_prio;

    always_comb begin
        starve_ok = (starve < CNT_W'(STARVE_MAX));
        // A d request still visible during its own completion pulse keeps
        // priority but is not granted; this holds i off for that one cycle
        // so a continuously requesting d-side is not penalised.
        d_prio  = d_req && starve_ok;
        grant_d = in_idle && d_prio && !d_dout_valid;
        grant_i = in_idle && !d_prio && i_req && !i_flush && !i_dout_valid;
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            starve <= '0;
        end else if (in_idle) begin
            if (grant_i || !i_req) begin
                starve <= '0;
            end else if (grant_d && starve_ok) begin
                starve <= starve + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single line-wide memory port between the instruction fetch
// queue (i-side, reads only, cancellable by branch redirect) and the
// load/store unit (d-side, reads and writes, never cancelled).
//   clock, nreset              clock and synchronous active-low reset
//   i_req/i_addr/i_flush       i-side line read request and redirect
//   i_dout/i_dout_valid        i-side read data and 1-cycle valid pulse
//   d_rd_req/d_wr_req/d_addr   d-side request, write wins if both set
//   d_wdata                    d-side write data
//   d_dout/d_dout_valid        d-side read data and completion pulse
//   mem_req/mem_we/mem_addr    memory transaction, stable while mem_req
//   mem_wdata                  memory write data
//   mem_rdata/mem_ready        memory read data and completion
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no transaction; arbitrate requests each cycle
// ST_I_BUSY  | i-side read in flight
// ST_I_DRAIN | i-side read flushed; wait for memory, drop the data
// ST_D_BUSY  | d-side read or write in flight
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = mips_mem_pkg::LINE_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic [LINE_W-1:0] i_dout,
    output logic              i_dout_valid,
    input  logic              d_rd_req,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_dout,
    output logic              d_dout_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t state, state_nxt;
    logic       grant_i, grant_d;
    logic       i_done, d_done;
    logic       in_idle;

    assign in_idle = (state == ST_IDLE);
    assign mem_req = !in_idle;

    arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clock        (clock),
        .nreset       (nreset),
        .in_idle      (in_idle),
        .i_req        (i_req),
        .i_flush      (i_flush),
        .i_dout_valid (i_dout_valid),
        .d_req        (d_rd_req || d_wr_req),
        .d_dout_valid (d_dout_valid),
        .grant_i      (grant_i),
        .grant_d      (grant_d)
    );

    always_comb begin
        state_nxt = state;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_d) begin
                    state_nxt = ST_D_BUSY;
                end else if (grant_i) begin
                    state_nxt = ST_I_BUSY;
                end
            end
            ST_I_BUSY: begin
                if (mem_ready) begin
                    state_nxt = ST_IDLE;
                    i_done    = !i_flush;
                end else if (i_flush) begin
                    state_nxt = ST_I_DRAIN;
                end
            end
            ST_I_DRAIN: begin
                if (mem_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_D_BUSY: begin
                if (mem_ready) begin
                    state_nxt = ST_IDLE;
                    d_done    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state        <= ST_IDLE;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_dout       <= '0;
            d_dout       <= '0;
            i_dout_valid <= 1'b0;
            d_dout_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            i_dout_valid <= i_done;
            d_dout_valid <= d_done;
            if (i_done) begin
                i_dout <= mem_rdata;
            end
            // Write completion pulses without touching the read data.
            if (d_done && !mem_we) begin
                d_dout <= mem_rdata;
            end
            if (grant_d) begin
                mem_we    <= d_wr_req;
                mem_addr  <= ADDR_W'(line_align(ADDR_MAX_W'(d_addr)));
                mem_wdata <= d_wr_req ? d_wdata : '0;
            end else if (grant_i) begin
                mem_we    <= 1'b0;
                mem_addr  <= ADDR_W'(line_align(ADDR_MAX_W'(i_addr)));
                mem_wdata <= '0;
            end else if (!in_idle && mem_ready) begin
                mem_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic         clock;
    logic         nreset;
    logic         i_req;
    logic [31:0]  i_addr;
    logic         i_flush;
    logic [127:0] i_dout;
    logic         i_dout_valid;
    logic         d_rd_req;
    logic         d_wr_req;
    logic [31:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] d_dout;
    logic         d_dout_valid;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .LINE_W     (128),
        .STARVE_MAX (4)
    ) dut (
        .clock        (clock),
        .nreset       (nreset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_flush      (i_flush),
        .i_dout       (i_dout),
        .i_dout_valid (i_dout_valid),
        .d_rd_req     (d_rd_req),
        .d_wr_req     (d_wr_req),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_dout       (d_dout),
        .d_dout_valid (d_dout_valid),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } tx_t;

    typedef struct {
        logic         wr;
        logic [127:0] data;
    } dexp_t;

    tx_t          exp_tx[$];
    logic [127:0] exp_i[$];
    dexp_t        exp_d[$];

    int vectors = 0;
    int errors  = 0;
    int i_pulses = 0;
    int d_pulses = 0;
    int lat = 0;

    logic [127:0] last_i, last_d;
    logic         prev_req;
    logic         prev_we;
    logic [31:0]  prev_addr;
    logic [127:0] prev_wdata;

    function automatic logic [127:0] mem_data(input logic [31:0] a);
        return {a ^ 32'hA5A5_A5A5, a, ~a, a + 32'h1234_5678};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Memory model: completes after `lat` wait cycles; data is a fixed
    // function of the line address, junk while not ready.
    int mcnt = 0;
    always @(negedge clock) begin
        if (mem_req) begin
            mcnt++;
            mem_ready = (mcnt == lat + 1);
            mem_rdata = mem_ready ? mem_data(mem_addr) : ~mem_data(mem_addr);
        end else begin
            mcnt = 0;
            mem_ready = 1'b0;
            mem_rdata = 128'h0BAD_0BAD;
        end
    end

    // Transaction-level checker: every memory transaction and every valid
    // pulse must match the next expectation, outputs hold otherwise.
    always @(negedge clock) begin
        if (!nreset) begin
            chk("rst_outputs",
                128'({mem_req, mem_we, i_dout_valid, d_dout_valid}), 128'(0));
            chk("rst_data", i_dout | d_dout | mem_wdata | 128'(mem_addr), 128'(0));
            exp_tx.delete();
            exp_i.delete();
            exp_d.delete();
            last_i   = '0;
            last_d   = '0;
            prev_req = 1'b0;
        end else begin
            if (!mem_req) chk("we_idle", 128'(mem_we), 128'(0));
            if (mem_req && !prev_req) begin
                if (exp_tx.size() == 0) begin
                    chk("tx_unexpected", 128'(mem_addr), 128'(0));
                end else begin
                    tx_t t;
                    t = exp_tx.pop_front();
                    chk("tx_we", 128'(mem_we), 128'(t.we));
                    chk("tx_addr", 128'(mem_addr), 128'(t.addr));
                    if (t.we) chk("tx_wdata", mem_wdata, t.wdata);
                end
            end
            if (mem_req && prev_req) begin
                chk("hold_mem", {mem_wdata[95:0], mem_addr}, {prev_wdata[95:0], prev_addr});
                chk("hold_we", 128'(mem_we), 128'(prev_we));
            end
            if (i_dout_valid) begin
                i_pulses++;
                if (exp_i.size() == 0) begin
                    chk("i_pulse_unexpected", 128'(i_dout_valid), 128'(0));
                end else begin
                    last_i = exp_i.pop_front();
                end
            end
            if (d_dout_valid) begin
                d_pulses++;
                if (exp_d.size() == 0) begin
                    chk("d_pulse_unexpected", 128'(d_dout_valid), 128'(0));
                end else begin
                    dexp_t e;
                    e = exp_d.pop_front();
                    if (!e.wr) last_d = e.data;
                end
            end
            chk("i_dout", i_dout, last_i);
            chk("d_dout", d_dout, last_d);
            prev_req   = mem_req;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic push_tx(input logic we, input logic [31:0] a, input logic [127:0] wd);
        tx_t t;
        t.we = we;
        t.addr = {a[31:4], 4'h0};
        t.wdata = wd;
        exp_tx.push_back(t);
    endtask

    task automatic push_d(input logic wr, input logic [31:0] a);
        dexp_t e;
        e.wr = wr;
        e.data = mem_data({a[31:4], 4'h0});
        exp_d.push_back(e);
    endtask

    task automatic wait_pulse(input bit is_i, input int target, input string name);
        int k = 0;
        while (((is_i ? i_pulses : d_pulses) < target) && k < 60) begin
            tick();
            k++;
        end
        chk(name, 128'((is_i ? i_pulses : d_pulses) >= target), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [127:0] wd;
    logic [9:0]   order;
    int           nrise, base, len, k;
    logic         pm;

    initial begin
        nreset = 1'b0; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_rd_req = 1'b0; d_wr_req = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        nreset = 1'b1;
        tick();

        // 1: i-only read
        lat = 3;
        push_tx(1'b0, 32'h0040_0014, '0);
        exp_i.push_back(mem_data(32'h0040_0010));
        i_req = 1'b1; i_addr = 32'h0040_0014;
        tick();
        chk("t1_latency", 128'(mem_req), 128'(1));
        chk("t1_addr", 128'(mem_addr), 128'(32'h0040_0010));
        chk("t1_we", 128'(mem_we), 128'(0));
        wait_pulse(1'b1, 1, "t1_wait");
        chk("t1_idata", i_dout, mem_data(32'h0040_0010));
        i_req = 1'b0;
        repeat (3) tick();
        chk("t1_i_pulses", 128'(i_pulses), 128'(1));
        chk("t1_d_pulses", 128'(d_pulses), 128'(0));

        // 2: d write, then read+write together (write wins)
        lat = 1;
        wd = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        push_tx(1'b1, 32'h1000_0008, wd);
        push_d(1'b1, 32'h1000_0008);
        d_wr_req = 1'b1; d_addr = 32'h1000_0008; d_wdata = wd;
        tick();
        chk("t2_we", 128'(mem_we), 128'(1));
        chk("t2_addr", 128'(mem_addr), 128'(32'h1000_0000));
        chk("t2_wdata", mem_wdata, wd);
        wait_pulse(1'b0, 1, "t2_wait");
        chk("t2_dout_kept", d_dout, 128'(0));
        d_wr_req = 1'b0;
        tick();
        push_tx(1'b1, 32'h1000_0050, ~wd);
        push_d(1'b1, 32'h1000_0050);
        d_wr_req = 1'b1; d_rd_req = 1'b1; d_addr = 32'h1000_0050; d_wdata = ~wd;
        wait_pulse(1'b0, 2, "t2b_wait");
        d_wr_req = 1'b0; d_rd_req = 1'b0;
        tick();

        // 3: contention, starvation limit 4
        lat = 1;
        for (int n = 0; n < 10; n++) begin
            if (n == 4 || n == 9) begin
                push_tx(1'b0, 32'h0040_0080, '0);
                exp_i.push_back(mem_data(32'h0040_0080));
            end else begin
                push_tx(1'b0, 32'h2000_0040, '0);
                push_d(1'b0, 32'h2000_0040);
            end
        end
        base = i_pulses;
        order = '0; nrise = 0; pm = 1'b0; k = 0;
        i_addr = 32'h0040_0080; d_addr = 32'h2000_0040;
        i_req = 1'b1; d_rd_req = 1'b1;
        while (i_pulses < base + 2 && k < 200) begin
            tick();
            k++;
            if (mem_req && !pm) begin
                order = {order[8:0], mem_addr == 32'h0040_0080};
                nrise++;
                if (nrise == 10) d_rd_req = 1'b0;
            end
            pm = mem_req;
        end
        i_req = 1'b0; d_rd_req = 1'b0;
        chk("t3_done", 128'(i_pulses >= base + 2), 128'(1));
        chk("t3_order", 128'(order), 128'(10'b0000100001));
        tick();

        // 4: flush while in flight, then a fresh i request
        lat = 4;
        base = i_pulses;
        push_tx(1'b0, 32'h0040_0200, '0);
        i_req = 1'b1; i_addr = 32'h0040_0200;
        tick();
        chk("t4_req", 128'(mem_req), 128'(1));
        i_flush = 1'b1; i_req = 1'b0; len = 1;
        tick();
        i_flush = 1'b0;
        k = 0;
        while (mem_req && k < 20) begin
            len++;
            tick();
            k++;
        end
        chk("t4_req_len", 128'(len), 128'(5));
        chk("t4_no_pulse", 128'(i_pulses), 128'(base));
        push_tx(1'b0, 32'h0040_0100, '0);
        exp_i.push_back(mem_data(32'h0040_0100));
        i_req = 1'b1; i_addr = 32'h0040_0100;
        tick();
        chk("t4_regrant", 128'(mem_req), 128'(1));
        wait_pulse(1'b1, base + 1, "t4_wait");
        i_req = 1'b0;
        tick();

        // 5: flush coinciding with mem_ready
        lat = 2;
        base = i_pulses;
        push_tx(1'b0, 32'h0040_0300, '0);
        i_req = 1'b1; i_addr = 32'h0040_0300;
        repeat (3) tick();
        i_flush = 1'b1; i_req = 1'b0;
        tick();
        i_flush = 1'b0;
        chk("t5_req_dropped", 128'(mem_req), 128'(0));
        chk("t5_no_pulse", 128'(i_dout_valid), 128'(0));
        push_tx(1'b0, 32'h3000_0010, '0);
        push_d(1'b0, 32'h3000_0010);
        base = d_pulses;
        d_rd_req = 1'b1; d_addr = 32'h3000_0010;
        tick();
        chk("t5_idle_grant", 128'(mem_req), 128'(1));
        wait_pulse(1'b0, base + 1, "t5_wait");
        d_rd_req = 1'b0;
        tick();

        // 6: reset during a d transaction
        lat = 10;
        push_tx(1'b0, 32'h4000_0020, '0);
        push_d(1'b0, 32'h4000_0020);
        d_rd_req = 1'b1; d_addr = 32'h4000_0020;
        repeat (2) tick();
        chk("t6_busy", 128'(mem_req), 128'(1));
        nreset = 1'b0; d_rd_req = 1'b0;
        tick();
        chk("t6_rst_req", 128'(mem_req), 128'(0));
        nreset = 1'b1;
        tick();
        lat = 1;
        base = d_pulses;
        push_tx(1'b0, 32'h4000_0030, '0);
        push_d(1'b0, 32'h4000_0030);
        d_rd_req = 1'b1; d_addr = 32'h4000_0030;
        tick();
        chk("t6_regrant", 128'(mem_req), 128'(1));
        wait_pulse(1'b0, base + 1, "t6_wait");
        d_rd_req = 1'b0;
        chk("t6_ddata", d_dout, mem_data(32'h4000_0030));
        repeat (3) tick();

        chk("end_tx_left", 128'(exp_tx.size()), 128'(0));
        chk("end_i_left", 128'(exp_i.size()), 128'(0));
        chk("end_d_left", 128'(exp_d.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
